cla_seq_adder16: RTL

CLA_SEQ_ADDER16 -- requirements
Module: cla_seq_adder16

---
 rtl/cla_seq_adder16_pkg.sv | 15 +
 rtl/cla_seq_adder16_cla4_slice.sv | 33 +++
 rtl/cla_seq_adder16.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cla_seq_adder16_pkg.sv
// Shared definitions for cla_seq_adder16: FSM states, slice width, NIBBLES bounds.
package cla_seq_adder16_pkg;

    localparam int unsigned SLICE_W     = 4;
    localparam int unsigned NIBBLES_MIN = 1;
    localparam int unsigned NIBBLES_MAX = 8;
    localparam int unsigned CNT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_seq_adder16_cla4_slice.sv
// 4-bit generate/propagate carry-lookahead adder slice, time-shared by cla_seq_adder16.
module cla4_slice
    import cla_seq_adder16_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_c,
    output logic [SLICE_W-1:0] o_s,
    output logic               o_c3,
    output logic               o_c4
);

    logic [SLICE_W-1:0] w_g;
    logic [SLICE_W-1:0] w_p;
    logic [SLICE_W:0]   w_c;

    assign w_g = i_a & i_b;
    assign w_p = i_a ^ i_b;

    assign w_c[0] = i_c;
    assign w_c[1] = w_g[0] | (w_p[0] & i_c);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & i_c);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & i_c);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & i_c);

    assign o_s  = w_p ^ w_c[SLICE_W-1:0];
    assign o_c3 = w_c[3];
    assign o_c4 = w_c[4];

endmodule

// File: rtl/cla_seq_adder16.sv
// Sequential adder: one shared 4-bit CLA slice processes one nibble per cycle.
// Optional subtract support is enabled by defining CLA_SEQ_ADDER_SUB_EN.
module cla_seq_adder16
    import cla_seq_adder16_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [SLICE_W*NIBBLES-1:0] a,
    input  logic [SLICE_W*NIBBLES-1:0] b,
    input  logic                       c_in,
    input  logic                       op_sub,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SLICE_W*NIBBLES-1:0] sum,
    output logic                       c_out,
    output logic                       ovf
);

    localparam int unsigned W = SLICE_W * NIBBLES;

    if (NIBBLES < NIBBLES_MIN || NIBBLES > NIBBLES_MAX) begin : g_bad_nibbles
        $error("cla_seq_adder16: NIBBLES out of range");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic               r_carry;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_last;
    logic               w_cin0;
    logic [SLICE_W-1:0] w_a_nib;
    logic [SLICE_W-1:0] w_b_raw;
    logic [SLICE_W-1:0] w_b_nib;
    logic [SLICE_W-1:0] w_s;
    logic               w_c3;
    logic               w_c4;

    assign w_accept = in_valid && (r_state == ST_IDLE);
    assign w_last   = (r_cnt == CNT_W'(NIBBLES - 1));

`ifdef CLA_SEQ_ADDER_SUB_EN
    logic r_sub;
    assign w_cin0  = op_sub ? 1'b1 : c_in;
    assign w_b_nib = r_sub ? ~w_b_raw : w_b_raw;
`else
    logic w_unused_sub;
    assign w_unused_sub = op_sub;
    assign w_cin0       = c_in;
    assign w_b_nib      = w_b_raw;
`endif

    always_comb begin
        w_a_nib = '0;
        w_b_raw = '0;
        for (int unsigned k = 0; k < NIBBLES; k++) begin
            if (r_cnt == CNT_W'(k)) begin
                w_a_nib = r_a[k*SLICE_W +: SLICE_W];
                w_b_raw = r_b[k*SLICE_W +: SLICE_W];
            end
        end
    end

    cla4_slice u_slice (
        .i_a  (w_a_nib),
        .i_b  (w_b_nib),
        .i_c  (r_carry),
        .o_s  (w_s),
        .o_c3 (w_c3),
        .o_c4 (w_c4)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Slice-0 carry-in is loaded into the running carry at acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
`ifdef CLA_SEQ_ADDER_SUB_EN
            r_sub   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_a     <= a;
            r_b     <= b;
            r_carry <= w_cin0;
`ifdef CLA_SEQ_ADDER_SUB_EN
            r_sub   <= op_sub;
`endif
        end else if (r_state == ST_RUN) begin
            r_cnt   <= r_cnt + CNT_W'(1);
            r_carry <= w_c4;
            for (int unsigned k = 0; k < NIBBLES; k++) begin
                if (r_cnt == CNT_W'(k)) begin
                    r_sum[k*SLICE_W +: SLICE_W] <= w_s;
                end
            end
            if (w_last) begin
                r_cout <= w_c4;
                r_ovf  <= w_c3 ^ w_c4;
            end
        end
    end

    assign in_ready  = rst_n && (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign sum       = r_sum;
    assign c_out     = r_cout;
    assign ovf       = r_ovf;

endmodule
